pbuff_write_ctrl: RTL and testbench
===================================

# pbuff_write_ctrl

Avalon-MM slave that sequences writes into the pixel buffer on behalf of the Nios II. It takes over the pixel-buffer write-enable role from a software-toggled output bit. Software programs a base address, pixel count and colour, then issues START. The block drives `pbuff_wren`/`pbuff_addr`/`pbuff_data` for one pixel per accepted cycle, honours `pbuff_ready` back-pressure, and raises a sticky DONE flag with an optional IRQ.

## Interface
- `ADDR_W`, 17, pixel-buffer address width
- `DATA_W`, 16, pixel data width
---
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `address`  in  2  register select
- `chipselect`  in  1  Avalon slave select
- `write_n`  in  1  active-low write strobe
- `writedata`  in  32  register write data
- `readdata`  out  32  register read data, combinational from `address`; zero-wait
- `irq`  out  1  DONE & IRQ_EN, level
- `pbuff_wren`  out  1  pixel write request, registered
- `pbuff_addr`  out  ADDR_W  pixel address, registered
- `pbuff_data`  out  DATA_W  pixel data, registered
- `pbuff_ready`  in  1  pixel buffer accepts the write this cycle

## Operation
- Register writes occur on `chipselect & ~write_n`.
- Register map:
  - 0 CTRL, write:
    - b0 START
    - b1 ABORT
    - b2 IRQ_EN, stored
    - b3 DONE_CLR, clears DONE and ABORTED
  - 0 STATUS, read:
    - b0 BUSY
    - b1 DONE
    - b2 IRQ_EN
    - b3 ABORTED
    - other bits 0
  - 1 BASE, ADDR_W bits, read/write
  - 2 COUNT: write sets the programmed count (ADDR_W+1 bits); read returns the live remaining count
  - 3 COLOR, DATA_W bits, read/write
- Unused upper bits read 0.
- FSM states: IDLE and RUN.
  - IDLE → RUN on START when COUNT≠0. On that edge, latch cur_addr←BASE, remaining←COUNT, data←COLOR; clear DONE and ABORTED.
  - START with COUNT=0: stay IDLE, set DONE on the write edge, no pixel writes.
  - In RUN, `pbuff_wren`=1. A transfer occurs when `pbuff_wren & pbuff_ready`. Each transfer does cur_addr←cur_addr+1 (mod 2^ADDR_W, wraps) and remaining←remaining−1.
  - RUN → IDLE on the transfer with remaining=1. On that edge: `pbuff_wren`←0 and DONE←1.
  - ABORT in RUN: → IDLE on the write edge, `pbuff_wren`←0, DONE←1, ABORTED←1. A transfer accepted in that same cycle still counts.
- Simultaneous events:
  - START while BUSY is ignored.
  - START+ABORT in one write: ABORT has priority; no run starts.
  - DONE_CLR in the same cycle DONE is set: set wins.
- Writes to BASE/COUNT/COLOR during RUN update the registers only. The active run uses its latched values.
- `pbuff_addr`/`pbuff_data` hold their last values when idle.

## Timing
- Reset values:
  - `pbuff_wren`=0, `pbuff_addr`=0, `pbuff_data`=0, `irq`=0
  - BASE=COUNT=COLOR=0
  - BUSY=DONE=ABORTED=IRQ_EN=0
- Reset asserted mid-run terminates the run immediately. No further writes after reset.
- START written on edge N: `pbuff_wren`=1 with addr=BASE from cycle N+1.
- With `pbuff_ready` held 1, a run of C pixels has `pbuff_wren` high for exactly C cycles, one address per cycle. BUSY drops and DONE rises on the edge that accepts the last pixel.
- A `pbuff_ready`=0 cycle stalls everything: wren, addr, data and remaining all hold.
- `irq` is combinational from registered DONE/IRQ_EN. It asserts in the cycle after the DONE edge and stays up until DONE_CLR or IRQ_EN=0.
- `readdata` reflects register state in the same cycle `address` is presented.

## Test plan
- Basic fill: BASE=0x100, COUNT=4, COLOR=0xF800, START, ready=1 → wren high 4 cycles at addr 0x100..0x103 with data 0xF800; STATUS then reads 0x2.
- Back-pressure: COUNT=3 with ready pattern 1,0,0,1,1 → addresses 0x100,0x101,0x101,0x101,0x102 presented; wren high 5 cycles; exactly 3 transfers.
- Wrap and zero: BASE=0x1FFFF, COUNT=2 → addrs 0x1FFFF then 0x00000. A separate COUNT=0 START → no wren, DONE=1 next read.
- Abort and priority: COUNT=100, ABORT after 10 transfers → wren low next cycle, COUNT reads 90, STATUS=0xA. START+ABORT issued from idle → no run.
- IRQ and clear: IRQ_EN=1, COUNT=1 run → irq=1 after completion; DONE_CLR → irq=0. START written during BUSY → ignored, remaining count unaffected.
- Reset mid-run: assert reset_n=0 after 5 transfers → wren, irq and all registers 0 immediately; no writes after release.

Source files
------------

// File: rtl/pbuff_write_ctrl.sv
// Avalon-MM slave that streams a solid colour into a run of pixel-buffer
// addresses. Software programs BASE/COUNT/COLOR and then writes START.
module pbuff_write_ctrl #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic              pbuff_wren,
  output logic [ADDR_W-1:0] pbuff_addr,
  output logic [DATA_W-1:0] pbuff_data,
  input  logic              pbuff_ready
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              irq_en_q, irq_en_d;

  logic reg_wr, ctrl_wr, start, abort, xfer;
  logic unused_wdata;

  assign reg_wr       = chipselect & ~write_n;
  assign ctrl_wr      = reg_wr && (address == 2'd0);
  assign start        = ctrl_wr & writedata[0];
  assign abort        = ctrl_wr & writedata[1];
  assign xfer         = (state_q == RUN) & pbuff_ready;
  assign unused_wdata = ^writedata[31:ADDR_W+1];

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    color_d     = color_q;
    addr_d      = addr_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    done_d      = done_q;
    aborted_d   = aborted_q;
    irq_en_d    = irq_en_q;

    // DONE_CLR is applied first so any same-cycle DONE set below overrides it.
    if (ctrl_wr) begin
      irq_en_d = writedata[2];
      if (writedata[3]) begin
        done_d    = 1'b0;
        aborted_d = 1'b0;
      end
    end

    if (reg_wr) begin
      case (address)
        2'd1:    base_d  = writedata[ADDR_W-1:0];
        2'd2:    count_d = writedata[ADDR_W:0];
        2'd3:    color_d = writedata[DATA_W-1:0];
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (count_q != '0) begin
            state_d     = RUN;
            addr_d      = base_q;
            remaining_d = count_q;
            data_d      = color_q;
            done_d      = 1'b0;
            aborted_d   = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          addr_d      = addr_q + ADDR_ONE;
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        // Abort still lets a transfer accepted on the same edge count above.
        if (abort) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      color_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      irq_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      color_q     <= color_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      irq_en_q    <= irq_en_d;
    end
  end

  assign pbuff_wren = (state_q == RUN);
  assign pbuff_addr = addr_q;
  assign pbuff_data = data_q;
  assign irq        = done_q & irq_en_q;

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[3:0]        = {aborted_q, irq_en_q, done_q, (state_q == RUN)};
      2'd1: readdata[ADDR_W-1:0] = base_q;
      2'd2: readdata[ADDR_W:0]   = remaining_q;
      2'd3: readdata[DATA_W-1:0] = color_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pbuff_write_ctrl.sv
// Directed plus randomized bench for pbuff_write_ctrl; expected pixel streams
// come from a per-run list of addresses base+i built before each START.
module tb_pbuff_write_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic        pbuff_wren;
  logic [16:0] pbuff_addr;
  logic [15:0] pbuff_data;
  logic        pbuff_ready = 1'b1;

  pbuff_write_ctrl #(.ADDR_W(17), .DATA_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .pbuff_wren (pbuff_wren),
    .pbuff_addr (pbuff_addr),
    .pbuff_data (pbuff_data),
    .pbuff_ready(pbuff_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: programmed registers and status bits.
  logic [16:0] m_base = '0;
  logic [17:0] m_count = '0;
  logic [15:0] m_color = '0;
  bit          m_irq_en = 1'b0;
  bit          m_done = 1'b0;
  bit          m_aborted = 1'b0;
  logic [15:0] run_color;
  logic [17:0] run_len;
  logic [16:0] exp_q[$];
  bit          pat_q[$];
  int          xf, st, wc, exp_xf;
  bit          aborted_run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  function automatic logic [31:0] status_exp();
    return {28'b0, m_aborted, m_irq_en, m_done, 1'b0};
  endfunction

  task automatic set_regs(input logic [16:0] b, input logic [17:0] c, input logic [15:0] col);
    bus_wr(2'd1, 32'(b));
    bus_wr(2'd2, 32'(c));
    bus_wr(2'd3, 32'(col));
    m_base = b; m_count = c; m_color = col;
  endtask

  task automatic start_run();
    exp_q.delete();
    for (int unsigned i = 0; i < m_count; i++) exp_q.push_back(17'(m_base + i));
    run_color = m_color;
    run_len   = m_count;
    bus_wr(2'd0, {29'b0, m_irq_en, 2'b01});
    if (m_count != 0) begin
      m_done = 1'b0; m_aborted = 1'b0;
    end else begin
      m_done = 1'b1;
    end
  endtask

  // Runs the pixel stream until wren drops, optionally issuing one register
  // write once xf transfers have been seen.
  task automatic service(input int ctrl_at, input logic [1:0] waddr,
                         input logic [31:0] wdata, input bit rnd);
    int cyc = 0;
    bit r, fired = 1'b0, now;
    xf = 0; st = 0; wc = 0; aborted_run = 1'b0; exp_xf = -1;
    while (pbuff_wren === 1'b1 && cyc < 400) begin
      if (exp_q.size() == 0) chk("extra_wren", {31'b0, pbuff_wren}, 32'h0);
      else begin
        chk("pix_addr", 32'(pbuff_addr), 32'(exp_q[0]));
        chk("pix_data", 32'(pbuff_data), 32'(run_color));
      end
      wc++;
      if (pat_q.size() > 0) r = pat_q.pop_front();
      else if (rnd) r = ($urandom_range(0, 2) != 0);
      else r = 1'b1;
      pbuff_ready = r;
      now = 1'b0;
      if (ctrl_at >= 0 && xf == ctrl_at && !fired) begin
        fired = 1'b1; now = 1'b1;
        chipselect = 1'b1; write_n = 1'b0; address = waddr; writedata = wdata;
      end
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      if (r) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        xf++;
      end else st++;
      if (now) begin
        case (waddr)
          2'd0: begin
            m_irq_en = wdata[2];
            if (wdata[1]) begin
              aborted_run = 1'b1;
              exp_xf = xf;
            end
          end
          2'd1: m_base  = wdata[16:0];
          2'd2: m_count = wdata[17:0];
          default: m_color = wdata[15:0];
        endcase
      end
      cyc++;
    end
    pbuff_ready = 1'b1;
    if (cyc >= 400) chk("run_timeout", 32'(cyc), 32'(0));
    m_done = 1'b1;
    m_aborted = aborted_run;
    exp_q.delete();
  endtask

  task automatic finish_check(input int want_xf, input string tag);
    chk({tag, "_xfers"}, 32'(xf), 32'(want_xf));
    chk({tag, "_wren_off"}, {31'b0, pbuff_wren}, 32'h0);
    rd(2'd0, status_exp(), {tag, "_status"});
    rd(2'd2, 32'(run_len - 18'(xf)), {tag, "_remaining"});
    chk({tag, "_irq"}, {31'b0, irq}, {31'b0, m_done & m_irq_en});
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_wren", {31'b0, pbuff_wren}, 32'h0);
    chk("rst_addr", 32'(pbuff_addr), 32'h0);
    chk("rst_data", 32'(pbuff_data), 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 4; a++) rd(2'(a), 32'h0, "rst_reg");
    @(negedge clk);
    reset_n = 1'b1;

    // Basic fill
    set_regs(17'h100, 18'd4, 16'hF800);
    start_run();
    service(-1, 2'd0, 32'h0, 1'b0);
    finish_check(4, "basic");
    chk("basic_wren_cycles", 32'(wc), 32'd4);
    rd(2'd0, 32'h2, "basic_status_const");
    rd(2'd1, 32'h100, "base_readback");
    rd(2'd3, 32'hF800, "color_readback");

    // Back-pressure pattern 1,0,0,1,1
    bus_wr(2'd2, 32'd3); m_count = 18'd3;
    pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    start_run();
    service(-1, 2'd0, 32'h0, 1'b0);
    finish_check(3, "bp");
    chk("bp_wren_cycles", 32'(wc), 32'd5);

    // Address wrap
    set_regs(17'h1FFFF, 18'd2, 16'h07E0);
    start_run();
    chk("wrap_first", 32'(pbuff_addr), 32'h1FFFF);
    service(-1, 2'd0, 32'h0, 1'b0);
    finish_check(2, "wrap");

    // Zero count: DONE only, no wren
    bus_wr(2'd2, 32'd0); m_count = '0;
    start_run();
    for (int i = 0; i < 3; i++) begin
      chk("zero_no_wren", {31'b0, pbuff_wren}, 32'h0);
      @(negedge clk);
    end
    rd(2'd0, 32'h2, "zero_status");

    // Abort after 10 transfers
    set_regs(17'h200, 18'd100, 16'h001F);
    start_run();
    service(9, 2'd0, 32'h2, 1'b0);
    finish_check(10, "abort");
    @(negedge clk);
    chk("abort_wren_stays", {31'b0, pbuff_wren}, 32'h0);
    rd(2'd0, 32'hA, "abort_status_const");
    rd(2'd2, 32'd90, "abort_count90");

    // DONE_CLR, then START+ABORT from idle starts nothing
    bus_wr(2'd0, 32'h8); m_done = 1'b0; m_aborted = 1'b0;
    rd(2'd0, 32'h0, "doneclr_status");
    bus_wr(2'd0, 32'h3);
    for (int i = 0; i < 3; i++) begin
      chk("startabort_no_wren", {31'b0, pbuff_wren}, 32'h0);
      @(negedge clk);
    end
    rd(2'd0, 32'h0, "startabort_status");
    rd(2'd2, 32'd90, "startabort_count");

    // IRQ behaviour
    m_irq_en = 1'b1;
    bus_wr(2'd2, 32'd1); m_count = 18'd1;
    start_run();
    chk("irq_low_busy", {31'b0, irq}, 32'h0);
    service(-1, 2'd0, 32'h0, 1'b0);
    finish_check(1, "irq");
    chk("irq_high", {31'b0, irq}, 32'h1);
    bus_wr(2'd0, 32'hC); m_done = 1'b0;
    chk("irq_doneclr", {31'b0, irq}, 32'h0);
    rd(2'd0, 32'h4, "irq_clr_status");
    start_run();
    service(-1, 2'd0, 32'h0, 1'b0);
    chk("irq_high2", {31'b0, irq}, 32'h1);
    bus_wr(2'd0, 32'h0); m_irq_en = 1'b0;
    chk("irq_en_off", {31'b0, irq}, 32'h0);
    rd(2'd0, 32'h2, "irq_off_status");

    // DONE_CLR on the completing edge: set wins
    bus_wr(2'd2, 32'd3); m_count = 18'd3;
    start_run();
    service(2, 2'd0, 32'h8, 1'b0);
    finish_check(3, "clr_race");

    // START while busy is ignored
    bus_wr(2'd2, 32'd6); m_count = 18'd6;
    start_run();
    service(2, 2'd0, 32'h1, 1'b0);
    finish_check(6, "busy_start");

    // BASE rewritten mid-run: current run keeps its latched base
    set_regs(17'h300, 18'd5, 16'hAAAA);
    start_run();
    service(1, 2'd1, 32'h1234, 1'b0);
    finish_check(5, "midrun_base");
    start_run();
    chk("new_base_used", 32'(pbuff_addr), 32'h1234);
    service(-1, 2'd0, 32'h0, 1'b0);
    finish_check(5, "new_base_run");

    // Randomized runs with random back-pressure and occasional abort
    for (int k = 0; k < 10; k++) begin
      int cat;
      m_irq_en = 1'($urandom_range(0, 1));
      set_regs(17'($urandom), 18'($urandom_range(1, 24)), 16'($urandom));
      start_run();
      cat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(m_count) - 1)) : -1;
      service(cat, 2'd0, {29'b0, m_irq_en, 2'b10}, 1'b1);
      finish_check(aborted_run ? exp_xf : int'(run_len), "rand");
    end

    // Reset mid-run
    m_irq_en = 1'b1;
    set_regs(17'h400, 18'd20, 16'h5555);
    start_run();
    pbuff_ready = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mrst_wren", {31'b0, pbuff_wren}, 32'h0);
    chk("mrst_irq", {31'b0, irq}, 32'h0);
    chk("mrst_addr", 32'(pbuff_addr), 32'h0);
    chk("mrst_data", 32'(pbuff_data), 32'h0);
    for (int a = 0; a < 4; a++) rd(2'(a), 32'h0, "mrst_reg");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mrst_no_wren", {31'b0, pbuff_wren}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
